// File: rtl/seg7_pkg.sv
// Shared constants for the BCD sum scan display: active-low segment patterns,
// internal digit codes and the scan FSM state type.
package seg7_pkg;

    // Segment order is {dp,g,f,e,d,c,b,a}, active-low.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [3:0] DIG_E     = 4'd10;
    localparam logic [3:0] DIG_BLANK = 4'd15;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

endpackage

// File: rtl/bcd_sum_scan_display_if.sv
// Capture strobe/data and display outputs of the BCD sum scan display.
interface bcd_sum_scan_display_if;
    logic       load;
    logic [3:0] bcd_in;
    logic       carry_in;
    logic [3:0] An;
    logic [7:0] Cout;
    logic       err;

    modport master (
        output load, bcd_in, carry_in,
        input  An, Cout, err
    );

    modport slave (
        input  load, bcd_in, carry_in,
        output An, Cout, err
    );
endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational digit-code to active-low seven-segment decoder.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            DIG_E:   seg = SEG_E;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_sum_scan_display.sv
// Latches a BCD sum/carry and scans it onto a 4-digit common-anode display,
// with one blank cycle between digits and an internal scan prescaler.
module bcd_sum_scan_display
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bcd_sum_scan_display_if.slave bus
);

    localparam int unsigned CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic          tick;
    scan_state_t   state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [3:0]    bcd_q;
    logic          carry_q, valid_q, err_q;
    logic [3:0]    d0, d1, code_d;
    logic [7:0]    seg_d;
    logic [3:0]    an_d, an_q;
    logic [7:0]    cout_d, cout_q;

    assign tick = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (bus.load) begin
            bcd_q   <= bus.bcd_in;
            carry_q <= bus.carry_in;
            valid_q <= 1'b1;
            err_q   <= (bus.bcd_in > 4'd9);
        end
    end

    // Digits stay blank until the first capture after reset.
    always_comb begin
        d0 = DIG_BLANK;
        d1 = DIG_BLANK;
        if (valid_q) begin
            d0 = err_q ? DIG_E : bcd_q;
            if (!err_q) begin
                if (carry_q)       d1 = 4'd1;
                else if (!BLANK_LZ) d1 = 4'd0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            ST_DRIVE: if (tick) begin
                state_d = ST_BLANK;
                sel_d   = sel_q + 2'd1;
            end
            ST_BLANK: state_d = ST_DRIVE;
            default:  state_d = ST_BLANK;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        an_d   = '1;
        code_d = DIG_BLANK;
        if (state_d == ST_DRIVE) begin
            an_d = ~(4'b0001 << sel_d);
            case (sel_d)
                2'd0:    code_d = d0;
                2'd1:    code_d = d1;
                default: code_d = DIG_BLANK;
            endcase
        end
        cout_d = (state_d == ST_DRIVE) ? seg_d : SEG_BLANK;
    end

    bcd_to_seg7 u_dec (
        .code (code_d),
        .seg  (seg_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BLANK;
            sel_q   <= '0;
            an_q    <= '1;
            cout_q  <= '1;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            an_q    <= an_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.An   = an_q;
    assign bus.Cout = cout_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd_sum_scan_display.sv
// Directed bench for bcd_sum_scan_display with SCAN_DIV=4, both BLANK_LZ settings.
module tb_bcd_sum_scan_display;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   ntests = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    bcd_sum_scan_display_if bus0 ();
    bcd_sum_scan_display_if bus1 ();

    bcd_sum_scan_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    bcd_sum_scan_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_load(input logic [3:0] bcd, input logic carry);
        @(negedge clk);
        bus0.load = 1'b1; bus0.bcd_in = bcd; bus0.carry_in = carry;
        bus1.load = 1'b1; bus1.bcd_in = bcd; bus1.carry_in = carry;
        @(negedge clk);
        bus0.load = 1'b0;
        bus1.load = 1'b0;
        repeat (16) @(negedge clk);
    endtask

    // Wait (bounded) for the anode of digit idx on one instance, then check its segments.
    task automatic find_digit(input string tag, input int inst, input int idx, input logic [7:0] exp);
        logic [3:0] target;
        logic [3:0] an;
        logic [7:0] cout;
        bit found;
        target = ~(4'b0001 << idx);
        found = 1'b0;
        cout = 8'h00;
        for (int i = 0; i < 24 && !found; i++) begin
            @(negedge clk);
            an   = (inst == 0) ? bus0.An : bus1.An;
            cout = (inst == 0) ? bus0.Cout : bus1.Cout;
            if (an == target) found = 1'b1;
        end
        check({tag, "_found"}, 32'(found), 32'd1);
        check(tag, 32'(cout), 32'(exp));
    endtask

    logic [3:0] frame_an [17] = '{4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF,
                                  4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF, 4'hE};

    initial begin
        bit found;
        bus0.load = 1'b0; bus0.bcd_in = '0; bus0.carry_in = 1'b0;
        bus1.load = 1'b0; bus1.bcd_in = '0; bus1.carry_in = 1'b0;

        @(negedge clk);
        check("rst_an", 32'(bus0.An), 32'hF);
        check("rst_cout", 32'(bus0.Cout), 32'hFF);
        check("rst_err", 32'(bus0.err), 32'd0);
        rst_n = 1'b1;

        // Frame structure right after reset release: 3 drive + 1 blank per digit.
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            check($sformatf("frame_an%0d", k), 32'(bus0.An), 32'(frame_an[k]));
            check($sformatf("frame_cout%0d", k), 32'(bus0.Cout), 32'hFF);
            check($sformatf("frame_onehot%0d", k), 32'($countones(~bus0.An) <= 1), 32'd1);
        end

        do_load(4'd7, 1'b0);
        check("err_7", 32'(bus0.err), 32'd0);
        find_digit("l7_d0", 0, 0, 8'hF8);
        find_digit("l7_d1", 0, 1, 8'hFF);
        find_digit("l7_d2", 0, 2, 8'hFF);
        find_digit("l7_d3", 0, 3, 8'hFF);
        find_digit("l7_lz0_d1", 1, 1, 8'hC0);

        do_load(4'd3, 1'b1);
        find_digit("l3c_d0", 0, 0, 8'hB0);
        find_digit("l3c_d1", 0, 1, 8'hF9);
        find_digit("l3c_lz0_d1", 1, 1, 8'hF9);

        do_load(4'd3, 1'b0);
        find_digit("l3_lz0_d0", 1, 0, 8'hB0);
        find_digit("l3_lz0_d1", 1, 1, 8'hC0);
        find_digit("l3_d1", 0, 1, 8'hFF);

        // err must be visible at the first sample after the capturing edge.
        @(negedge clk);
        bus0.load = 1'b1; bus0.bcd_in = 4'd12; bus0.carry_in = 1'b1;
        bus1.load = 1'b1; bus1.bcd_in = 4'd12; bus1.carry_in = 1'b1;
        @(negedge clk);
        bus0.load = 1'b0; bus1.load = 1'b0;
        check("err_12", 32'(bus0.err), 32'd1);
        find_digit("l12_d0", 0, 0, 8'h86);
        find_digit("l12_d1", 0, 1, 8'hFF);
        find_digit("l12_lz0_d1", 1, 1, 8'hFF);

        do_load(4'd5, 1'b0);
        check("err_5", 32'(bus0.err), 32'd0);
        find_digit("l5_d0", 0, 0, 8'h92);

        // Asynchronous reset in the middle of a drive slot.
        found = 1'b0;
        for (int i = 0; i < 24 && !found; i++) begin
            @(negedge clk);
            if (bus0.An == 4'hE) found = 1'b1;
        end
        check("arst_found", 32'(found), 32'd1);
        check("arst_pre_cout", 32'(bus0.Cout), 32'h92);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_an", 32'(bus0.An), 32'hF);
        check("arst_cout", 32'(bus0.Cout), 32'hFF);
        check("arst_err", 32'(bus0.err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_an", 32'(bus0.An), 32'hE);
        check("rel_cout", 32'(bus0.Cout), 32'hFF);
        check("rel_err", 32'(bus0.err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/bcd_sum_scan_display.md
Name: bcd_sum_scan_display

Overview:
- Downstream stage of the BCD adder: latches the 4-bit BCD sum and carry, splits them into a tens/ones pair and drives a 4-digit common-anode seven-segment display.
- Display is time-multiplexed, with an internal scan prescaler so no separate divided clock is needed.
- Flags sums that are not valid BCD (above 9) and shows "E" instead of a number.
- Replaces the divider-plus-display pair on the board with one synchronous block in the single system clock domain.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot; legal range 2..2^20.
- BLANK_LZ, 1, 1 = blank the tens digit when it is 0; 0 = show "0".

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  single-cycle strobe; captures bcd_in/carry_in.
- bcd_in  in  4  BCD sum digit from the adder.
- carry_in  in  1  decimal carry (tens digit = 1).
- An  out  4  digit anodes, active-low, one-hot-low; An[0] = rightmost digit.
- Cout  out  8  segments {dp,g,f,e,d,c,b,a}, active-low; dp always 1.
- err  out  1  high while the latched bcd_in is greater than 9.

Behaviour:
Reset (async assert, sync release):
- An=4'b1111, Cout=8'hFF, err=0.
- Latched value is cleared; all four digits are blank.
- sel=0, prescaler=0, FSM=BLANK.

Capture:
- load=1 at edge n: registers bcd_in and carry_in; err updates at edge n.
- Digit values:
  - d0 = bcd_in, or "E" if bcd_in>9.
  - d1 = 1 if carry_in, else 0 (blank if BLANK_LZ and 0; blank whenever err=1).
  - d2 and d3 are always blank.
- load does not reset sel or the prescaler.
- The new value appears on Cout no later than the next DRIVE slot of each digit.

Prescaler:
- Counts 0..SCAN_DIV-1 and wraps.
- Emits tick for one cycle at terminal count.

Scan FSM (two states, sel is 2 bits):
- DRIVE:
  - An = ~(4'b0001<<sel); Cout = decode(d[sel]); both registered.
  - On tick: go to BLANK and advance sel (3 wraps to 0).
- BLANK:
  - Exactly one cycle with An=4'b1111, Cout=8'hFF (anti-ghosting).
  - Then go to DRIVE.
- After reset the first DRIVE starts on the cycle after reset release, with sel=0.
- Digit period is SCAN_DIV cycles, including the one BLANK cycle. Full frame is 4*SCAN_DIV cycles.

Decode (active-low):
- 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
- E=86, blank=FF.
- Any unlisted code decodes to blank.

Simultaneous events:
- load coinciding with tick: the capture wins. The newly driven digit uses the new value one cycle later (registered decode path).
- Reset mid-scan: outputs go immediately to their reset values.

Decomposition:
- Package seg7_pkg:
  - segment constants SEG_0..SEG_9, SEG_E, SEG_BLANK;
  - digit-code constants DIG_E, DIG_BLANK (4-bit internal codes 10 and 15);
  - FSM state encoding.
- Sub-module bcd_to_seg7: purely combinational, 4-bit code in, 8-bit active-low segments out.
- Prescaler, FSM, capture registers and output registers stay in the top block.

Test Plan (SCAN_DIV=4 in simulation):
- Reset held low, then released → An=1111, Cout=FF during reset. First DRIVE has An=1110, Cout=FF (blank before any load). err=0.
- load with bcd_in=7, carry_in=0 → over one frame:
  - An=1110 shows F8;
  - An=1101 shows FF (leading zero blanked);
  - An=1011 and An=0111 show FF.
- load with bcd_in=3, carry_in=1 → digit 0 shows B0, digit 1 shows F9. Repeat with BLANK_LZ=0 and carry_in=0: digit 1 shows C0.
- load with bcd_in=12 → err=1 on the following cycle. Digit 0 shows 86, digit 1 shows FF. A later load of 5 clears err, and digit 0 shows 92.
- Observe a full frame → every anode change is preceded by exactly one cycle of An=1111/Cout=FF. Never more than one An bit is low. Each digit period is 4 cycles and the order is 0,1,2,3,0.
- Assert rst_n low mid-DRIVE and asynchronously to clk → An=1111 and Cout=FF with no clock edge. After release the scan restarts at sel=0 and the latched value is cleared.
